// File: rtl/ex_stage_alu_pkg.sv
// Shared constants for the execute stage: ALU operation codes
// (also used by the ALU control decoder) and forward selects.
package ex_stage_alu_pkg;

   localparam logic [3:0] ALUAND = 4'b0000;
   localparam logic [3:0] ALUOR  = 4'b0001;
   localparam logic [3:0] ALUADD = 4'b0010;
   localparam logic [3:0] ALUXOR = 4'b0011;
   localparam logic [3:0] ALUSUB = 4'b0110;
   localparam logic [3:0] ALUSLT = 4'b0111;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_WB    = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/ex_stage_alu_alu_core.sv
// Combinational ALU: result, zero flag and undefined-code flag.
module alu_core
   import ex_stage_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      alu_controle,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (alu_controle)
         ALUAND: result = a & b;
         ALUOR:  result = a | b;
         ALUADD: result = a + b;
         ALUXOR: result = a ^ b;
         ALUSUB: result = a - b;
         ALUSLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         default: illegal = 1'b1;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex_stage_alu.sv
// RV32 execute stage: operand forwarding, ALU, BEQ resolution
// and the EX/MEM pipeline register.
module ex_stage_alu
   import ex_stage_alu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int REGADDR = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [3:0]         alu_controle,
   input  logic [XLEN-1:0]    rs1_data,
   input  logic [XLEN-1:0]    rs2_data,
   input  logic [XLEN-1:0]    imm,
   input  logic [XLEN-1:0]    pc_in,
   input  logic               alu_src,
   input  logic [1:0]         fwd_a,
   input  logic [1:0]         fwd_b,
   input  logic [XLEN-1:0]    memwb_data,
   input  logic [REGADDR-1:0] rd_in,
   input  logic               reg_write_in,
   input  logic               mem_read_in,
   input  logic               mem_write_in,
   input  logic               mem_to_reg_in,
   input  logic               branch_in,
   input  logic               stall,
   input  logic               flush,
   output logic               out_valid,
   output logic [XLEN-1:0]    alu_result,
   output logic [XLEN-1:0]    store_data,
   output logic [REGADDR-1:0] rd_out,
   output logic               reg_write_out,
   output logic               mem_read_out,
   output logic               mem_write_out,
   output logic               mem_to_reg_out,
   output logic               zero_out,
   output logic               branch_taken,
   output logic [XLEN-1:0]    branch_target,
   output logic               alu_illegal
);

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] fwd_b_val;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] res;
   logic            zero;
   logic            illegal;
   logic            v;

   // Reserved select 11 falls back to the register file value
   always_comb begin
      case (fwd_a)
         FWD_WB:    op_a = memwb_data;
         FWD_EXMEM: op_a = alu_result;
         default:   op_a = rs1_data;
      endcase
      case (fwd_b)
         FWD_WB:    fwd_b_val = memwb_data;
         FWD_EXMEM: fwd_b_val = alu_result;
         default:   fwd_b_val = rs2_data;
      endcase
   end

   assign op_b = alu_src ? imm : fwd_b_val;
   assign v    = in_valid & ~flush;

   alu_core #(.XLEN(XLEN)) u_alu (
      .a            (op_a),
      .b            (op_b),
      .alu_controle (alu_controle),
      .result       (res),
      .zero         (zero),
      .illegal      (illegal)
   );

   // Flush overrides stall so a bubble is always inserted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         alu_result     <= '0;
         store_data     <= '0;
         rd_out         <= '0;
         reg_write_out  <= 1'b0;
         mem_read_out   <= 1'b0;
         mem_write_out  <= 1'b0;
         mem_to_reg_out <= 1'b0;
         zero_out       <= 1'b0;
         branch_taken   <= 1'b0;
         branch_target  <= '0;
         alu_illegal    <= 1'b0;
      end else if (flush || !stall) begin
         out_valid      <= v;
         alu_result     <= res;
         store_data     <= fwd_b_val;
         rd_out         <= rd_in;
         reg_write_out  <= v & reg_write_in & ~illegal;
         mem_read_out   <= v & mem_read_in & ~illegal;
         mem_write_out  <= v & mem_write_in & ~illegal;
         mem_to_reg_out <= v & mem_to_reg_in;
         zero_out       <= zero;
         branch_taken   <= v & branch_in & zero;
         branch_target  <= pc_in + imm;
         alu_illegal    <= v & illegal;
      end
   end

endmodule

// File: tb/tb_ex_stage_alu.sv
// Self-checking bench for ex_stage_alu with a behavioural model
// and an expected-result queue.
module tb_ex_stage_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  alu_controle;
   logic [31:0] rs1_data, rs2_data, imm, pc_in, memwb_data;
   logic        alu_src;
   logic [1:0]  fwd_a, fwd_b;
   logic [4:0]  rd_in;
   logic        reg_write_in, mem_read_in, mem_write_in;
   logic        mem_to_reg_in, branch_in, stall, flush;
   logic        out_valid;
   logic [31:0] alu_result, store_data, branch_target;
   logic [4:0]  rd_out;
   logic        reg_write_out, mem_read_out, mem_write_out;
   logic        mem_to_reg_out, zero_out, branch_taken, alu_illegal;

   typedef struct packed {
      logic        v;
      logic [31:0] res;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic        rw, mr, mw, m2r, z, bt;
      logic [31:0] tgt;
      logic        ill;
   } exp_t;

   exp_t m;
   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   ex_stage_alu dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .alu_controle(alu_controle), .rs1_data(rs1_data),
      .rs2_data(rs2_data), .imm(imm), .pc_in(pc_in),
      .alu_src(alu_src), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .memwb_data(memwb_data), .rd_in(rd_in),
      .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
      .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
      .branch_in(branch_in), .stall(stall), .flush(flush),
      .out_valid(out_valid), .alu_result(alu_result),
      .store_data(store_data), .rd_out(rd_out),
      .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
      .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out),
      .zero_out(zero_out), .branch_taken(branch_taken),
      .branch_target(branch_target), .alu_illegal(alu_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input exp_t cur);
      exp_t        n;
      logic [31:0] a, fb, b, r;
      logic        il, vv;
      a  = (fwd_a == 2'b01) ? memwb_data :
           (fwd_a == 2'b10) ? cur.res : rs1_data;
      fb = (fwd_b == 2'b01) ? memwb_data :
           (fwd_b == 2'b10) ? cur.res : rs2_data;
      b  = alu_src ? imm : fb;
      il = 1'b0;
      r  = 32'h0;
      if      (alu_controle == 4'd0) r = a & b;
      else if (alu_controle == 4'd1) r = a | b;
      else if (alu_controle == 4'd2) r = a + b;
      else if (alu_controle == 4'd3) r = a ^ b;
      else if (alu_controle == 4'd6) r = a - b;
      else if (alu_controle == 4'd7)
         r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      else il = 1'b1;
      vv    = in_valid && !flush;
      n.v   = vv;
      n.res = r;
      n.sd  = fb;
      n.rd  = rd_in;
      n.rw  = vv && reg_write_in && !il;
      n.mr  = vv && mem_read_in && !il;
      n.mw  = vv && mem_write_in && !il;
      n.m2r = vv && mem_to_reg_in;
      n.z   = (r == 32'h0);
      n.bt  = vv && branch_in && (r == 32'h0);
      n.tgt = pc_in + imm;
      n.ill = vv && il;
      if (!rst_n) return '0;
      if (stall && !flush) return cur;
      return n;
   endfunction

   task automatic step();
      exp_t e;
      e = model(m);
      q.push_back(e);
      m = e;
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk("valid", {31'b0, out_valid}, {31'b0, e.v});
      chk("result", alu_result, e.res);
      chk("store", store_data, e.sd);
      chk("rd", {27'b0, rd_out}, {27'b0, e.rd});
      chk("ctrl",
          {28'b0, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out},
          {28'b0, e.rw, e.mr, e.mw, e.m2r});
      chk("zero", {31'b0, zero_out}, {31'b0, e.z});
      chk("taken", {31'b0, branch_taken}, {31'b0, e.bt});
      chk("target", branch_target, e.tgt);
      chk("illegal", {31'b0, alu_illegal}, {31'b0, e.ill});
   endtask

   task automatic op(input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b);
      in_valid      = 1'b1;
      alu_controle  = c;
      rs1_data      = a;
      rs2_data      = b;
      imm           = 32'h0;
      pc_in         = 32'h0;
      alu_src       = 1'b0;
      fwd_a         = 2'b00;
      fwd_b         = 2'b00;
      memwb_data    = 32'h0;
      rd_in         = 5'd1;
      reg_write_in  = 1'b0;
      mem_read_in   = 1'b0;
      mem_write_in  = 1'b0;
      mem_to_reg_in = 1'b0;
      branch_in     = 1'b0;
      stall         = 1'b0;
      flush         = 1'b0;
   endtask

   initial begin
      logic [3:0] codes [8];
      codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd5, 4'd15};
      m = '1;
      op(4'd2, 32'h0, 32'h0);
      rst_n = 1'b0;
      step();
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      rst_n = 1'b1;

      op(4'd2, 32'd5, 32'd7);
      reg_write_in = 1'b1;
      rd_in = 5'd3;
      step();
      chk("add_direct", alu_result, 32'd12);

      op(4'd7, 32'hFFFF_FFFF, 32'd1);
      step();
      chk("slt_neg", alu_result, 32'd1);
      op(4'd7, 32'd1, 32'hFFFF_FFFF);
      step();
      chk("slt_pos", alu_result, 32'd0);

      op(4'd6, 32'h10, 32'h10);
      branch_in = 1'b1;
      pc_in = 32'h40;
      imm = 32'hFFFF_FFF8;
      step();
      chk("beq_tgt", branch_target, 32'h38);
      chk("beq_taken", {31'b0, branch_taken}, 32'd1);
      rs2_data = 32'h11;
      step();
      chk("beq_not", {31'b0, branch_taken}, 32'd0);

      op(4'd2, 32'h80, 32'h80);
      step();
      op(4'd2, 32'h0, 32'h0);
      fwd_a = 2'b10;
      imm = 32'd4;
      alu_src = 1'b1;
      step();
      chk("fwd_exmem", alu_result, 32'h104);
      op(4'd2, 32'h1, 32'h2);
      fwd_b = 2'b01;
      memwb_data = 32'hAB;
      mem_write_in = 1'b1;
      step();
      chk("fwd_wb", store_data, 32'hAB);

      op(4'd3, 32'hF0F0, 32'h0FF0);
      fwd_a = 2'b11;
      reg_write_in = 1'b1;
      step();
      op(4'd1, 32'h1234, 32'h4321);
      stall = 1'b1;
      step();
      step();
      chk("stall_hold", alu_result, 32'hF0F0 ^ 32'h0FF0);
      fwd_a = 2'b10;
      step();

      op(4'd2, 32'd9, 32'd9);
      reg_write_in = 1'b1;
      flush = 1'b1;
      step();
      chk("flush_rw", {31'b0, reg_write_out}, 32'd0);
      op(4'd2, 32'd3, 32'd3);
      reg_write_in = 1'b1;
      step();
      stall = 1'b1;
      flush = 1'b1;
      step();

      op(4'd15, 32'd3, 32'd4);
      reg_write_in = 1'b1;
      mem_read_in = 1'b1;
      step();
      chk("ill_flag", {31'b0, alu_illegal}, 32'd1);

      op(4'd0, 32'hFF00, 32'h0FF0);
      mem_to_reg_in = 1'b1;
      step();
      stall = 1'b1;
      rst_n = 1'b0;
      step();
      chk("rst_stall", alu_result, 32'd0);
      rst_n = 1'b1;
      stall = 1'b0;

      for (int i = 0; i < 40; i++) begin
         op(codes[$urandom_range(0, 7)], $urandom, $urandom);
         in_valid      = ($urandom_range(0, 7) != 0);
         imm           = $urandom;
         pc_in         = $urandom;
         memwb_data    = $urandom;
         alu_src       = $urandom_range(0, 1);
         fwd_a         = 2'($urandom_range(0, 3));
         fwd_b         = 2'($urandom_range(0, 3));
         rd_in         = 5'($urandom);
         reg_write_in  = $urandom_range(0, 1);
         mem_read_in   = $urandom_range(0, 1);
         mem_write_in  = $urandom_range(0, 1);
         mem_to_reg_in = $urandom_range(0, 1);
         branch_in     = $urandom_range(0, 1);
         if ($urandom_range(0, 3) == 0) rs2_data = rs1_data;
         stall         = ($urandom_range(0, 5) == 0);
         flush         = ($urandom_range(0, 7) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ex_stage_alu.md
Name: ex_stage_alu

Overview:
- Execute stage of the RV32 reduced-ISA 5-stage pipeline.
- Consumes the 4-bit ALU control code produced by the ALU control decoder, selects forwarded operands and performs the ALU operation.
- Resolves BEQ and registers everything into the EX/MEM pipeline register.
- Sits between the ID/EX register and the data-memory stage; the hazard unit drives its stall/flush/forward inputs.

Parameters:
- XLEN, 32, datapath width
- REGADDR, 5, register-index width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  ID/EX slot holds a real instruction
- alu_controle  in  4  ALU operation code from the ALU control decoder
- rs1_data  in  XLEN  register-file operand A
- rs2_data  in  XLEN  register-file operand B
- imm  in  XLEN  sign-extended immediate; for branches, already the byte offset
- pc_in  in  XLEN  PC of the instruction
- alu_src  in  1  1 = operand B is imm
- fwd_a  in  2  operand A forward select
- fwd_b  in  2  operand B forward select
- memwb_data  in  XLEN  MEM/WB writeback value for forwarding
- rd_in  in  REGADDR  destination register
- reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in  in  1 each  control bits
- stall  in  1  hold EX/MEM register
- flush  in  1  insert bubble
- out_valid  out  1  EX/MEM slot valid
- alu_result  out  XLEN  registered ALU result
- store_data  out  XLEN  registered forwarded rs2 value
- rd_out  out  REGADDR  registered destination register
- reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out  out  1 each  registered control bits
- zero_out  out  1  registered alu_result==0
- branch_taken  out  1  registered BEQ taken
- branch_target  out  XLEN  registered pc_in+imm
- alu_illegal  out  1  registered: valid instruction carried an undefined code

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous, active-low: on a rising clk edge with rst_n=0, every output register is cleared to 0, including out_valid, all control bits, data buses and flags.
- Latency: exactly 1 cycle, input sample to EX/MEM output.
- Operand A by fwd_a:
  - 00: rs1_data
  - 01: memwb_data
  - 10: own registered alu_result (EX/MEM forward)
  - 11: reserved, treated as 00
- fwd_b selects the forwarded B operand the same way; this value becomes store_data. Operand B = imm if alu_src=1, else the forwarded B.
- Operations (codes fixed in params.v):
  - ALUAND=0000: A&B
  - ALUOR=0001: A|B
  - ALUADD=0010: A+B mod 2^32
  - ALUXOR=0011: A^B
  - ALUSUB=0110: A−B mod 2^32
  - ALUSLT=0111: signed compare, result 1 or 0, zero-extended
- Any other code gives result 0. If in_valid=1, the stage also sets alu_illegal=1 and forces reg_write_out, mem_read_out and mem_write_out to 0.
- zero_out = (result==0).
- branch_taken = in_valid & branch_in & (result==0). BEQ arrives with ALUSUB.
- branch_target = pc_in+imm mod 2^32, always computed.
- Control outputs are the inputs ANDed with in_valid. in_valid=0 loads a bubble: all control bits, out_valid, branch_taken and alu_illegal are 0; data buses load their computed values (don't-care to consumers).
- stall=1: every output register holds its value. EX/MEM forwarding (fwd=10) keeps using the held alu_result.
- flush=1: loads a bubble regardless of in_valid.
- Priority: reset > flush > stall > normal load. Flush and stall together gives a bubble.
- Reset mid-stall: the cleared state wins; no held value survives.

Decomposition:
- params.v holds the ALU code constants listed above, which are shared with the ALU control decoder, plus the forward-select constants FWD_RF=00, FWD_WB=01, FWD_EXMEM=10.
- One combinational sub-module, alu_core: inputs a, b, alu_controle; outputs result, zero, illegal. Operand muxing and the EX/MEM register stay in ex_stage_alu.

Test Plan:
- ADD: rs1=5, rs2=7, alu_src=0, code 0010, reg_write_in=1 -> next cycle alu_result=12, reg_write_out=1, out_valid=1.
- SLT signed: rs1=0xFFFFFFFF, rs2=1, code 0111 -> alu_result=1. Swap the operands -> 0.
- BEQ: rs1=rs2=0x10, code 0110, branch_in=1, pc_in=0x40, imm=0xFFFFFFF8 -> branch_taken=1, branch_target=0x38, zero_out=1. With rs2=0x11 -> branch_taken=0.
- Forwarding: cycle N ADD gives alu_result=0x100. Cycle N+1 fwd_a=10, imm=4, alu_src=1, ADD -> 0x104. Then fwd_b=01 with memwb_data=0xAB and mem_write_in=1 -> store_data=0xAB.
- Stall/flush: assert stall for 2 cycles -> all outputs hold. Then flush with valid input -> out_valid=0, reg_write_out=0. Then stall+flush together -> bubble.
- Illegal and reset:
  - code 1111 with in_valid=1, reg_write_in=1 -> alu_illegal=1, alu_result=0, reg_write_out=0.
  - rst_n=0 for one cycle during stall -> all outputs 0 on that edge.
